// File: rtl/mvd_search_ctrl.sv
`default_nettype none
// ============================================================================
// mvd_search_ctrl : raster MV search driver for the pipelined MVD cost engine
// Rev 1.0
// ============================================================================
module mvd_search_ctrl #(
    parameter int RANGE_W    = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               start,
    input  logic [31:0]        center_x,
    input  logic [31:0]        center_y,
    input  logic [RANGE_W-1:0] range,
    input  logic [31:0]        mv_shift_in,
    input  logic [15:0]        cand_in_0,
    input  logic [15:0]        cand_in_1,
    input  logic [15:0]        cand_in_2,
    input  logic [15:0]        cand_in_3,
    input  logic [63:0]        lambda_int_in,
    input  logic [63:0]        lambda_dec_in,
    output logic               eng_start,
    output logic               eng_ce,
    output logic [31:0]        eng_x,
    output logic [31:0]        eng_y,
    output logic [31:0]        eng_mv_shift,
    output logic [15:0]        eng_cand_0,
    output logic [15:0]        eng_cand_1,
    output logic [15:0]        eng_cand_2,
    output logic [15:0]        eng_cand_3,
    output logic [63:0]        eng_lambda_int,
    output logic [63:0]        eng_lambda_dec,
    input  logic [63:0]        eng_cost,
    input  logic               eng_cost_vld,
    input  logic [63:0]        eng_bitcost,
    output logic               busy,
    output logic               done,
    output logic [31:0]        best_x,
    output logic [31:0]        best_y,
    output logic [63:0]        best_cost,
    output logic [63:0]        best_bitcost,
    output logic               err_orphan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [FIFO_AW:0]   FIFO_FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE       = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE       = FIFO_AW'(1);

    state_t             state, state_nxt;
    logic [31:0]        lo_x, hi_x, hi_y, cur_x, cur_y;
    logic [31:0]        range_ext;
    logic [63:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [31:0]        head_x, head_y;
    logic               fifo_full, fifo_empty, pop, orphan, last_pt, accept;

    assign range_ext        = 32'(range);
    assign fifo_full        = (count == FIFO_FULL_CNT);
    assign fifo_empty       = (count == '0);
    assign {head_x, head_y} = fifo_mem[rd_ptr];
    assign accept           = (state == IDLE) && start;
    assign pop              = eng_cost_vld && !fifo_empty && (state != IDLE);
    assign orphan           = eng_cost_vld && fifo_empty;
    assign last_pt          = (cur_x == hi_x) && (cur_y == hi_y);
    assign eng_x            = cur_x;
    assign eng_y            = cur_y;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        eng_ce    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                eng_ce    = 1'b1;
                busy      = 1'b1;
                eng_start = !fifo_full;
                if (!fifo_full && last_pt) state_nxt = DRAIN;
            end
            DRAIN: begin
                eng_ce = 1'b1;
                busy   = 1'b1;
                // A result arriving this cycle may still be in flight behind it
                if (fifo_empty && !eng_cost_vld) state_nxt = DONE;
            end
            DONE: begin
                eng_ce    = 1'b1;
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coordinate tag storage needs no reset: occupancy is tracked by count
    always_ff @(posedge ap_clk) begin
        if (eng_start) fifo_mem[wr_ptr] <= {cur_x, cur_y};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lo_x           <= '0;
            hi_x           <= '0;
            hi_y           <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
            eng_mv_shift   <= '0;
            eng_cand_0     <= '0;
            eng_cand_1     <= '0;
            eng_cand_2     <= '0;
            eng_cand_3     <= '0;
            eng_lambda_int <= '0;
            eng_lambda_dec <= '0;
            best_x         <= '0;
            best_y         <= '0;
            best_cost      <= '0;
            best_bitcost   <= '0;
            err_orphan     <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else begin
            if (accept) begin
                lo_x           <= center_x - range_ext;
                hi_x           <= center_x + range_ext;
                hi_y           <= center_y + range_ext;
                cur_x          <= center_x - range_ext;
                cur_y          <= center_y - range_ext;
                eng_mv_shift   <= mv_shift_in;
                eng_cand_0     <= cand_in_0;
                eng_cand_1     <= cand_in_1;
                eng_cand_2     <= cand_in_2;
                eng_cand_3     <= cand_in_3;
                eng_lambda_int <= lambda_int_in;
                eng_lambda_dec <= lambda_dec_in;
                best_x         <= '0;
                best_y         <= '0;
                best_cost      <= '1;
                best_bitcost   <= '0;
                err_orphan     <= 1'b0;
            end
            if (eng_start) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (cur_x == hi_x) begin
                    cur_x <= lo_x;
                    cur_y <= cur_y + 32'd1;
                end else begin
                    cur_x <= cur_x + 32'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                // Strict compare keeps the earliest raster point on ties
                if (eng_cost < best_cost) begin
                    best_x       <= head_x;
                    best_y       <= head_y;
                    best_cost    <= eng_cost;
                    best_bitcost <= eng_bitcost;
                end
            end
            if (orphan) err_orphan <= 1'b1;
            case ({eng_start, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvd_search_ctrl.sv
`default_nettype none
// Testbench for mvd_search_ctrl: behavioural engine model plus scoreboard of
// expected issue order and final best-MV results.
module tb_mvd_search_ctrl;

    localparam int RANGE_W    = 6;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        center_x = '0, center_y = '0, mv_shift_in = '0;
    logic [RANGE_W-1:0] range = '0;
    logic [15:0]        cand_in_0 = '0, cand_in_1 = '0, cand_in_2 = '0, cand_in_3 = '0;
    logic [63:0]        lambda_int_in = '0, lambda_dec_in = '0;
    logic               eng_start, eng_ce, busy, done, err_orphan;
    logic [31:0]        eng_x, eng_y, eng_mv_shift, best_x, best_y;
    logic [15:0]        eng_cand_0, eng_cand_1, eng_cand_2, eng_cand_3;
    logic [63:0]        eng_lambda_int, eng_lambda_dec, best_cost, best_bitcost;
    logic [63:0]        eng_cost = '0, eng_bitcost = '0;
    logic               eng_cost_vld = 1'b0;

    mvd_search_ctrl #(.RANGE_W(RANGE_W), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
        .center_x(center_x), .center_y(center_y), .range(range), .mv_shift_in(mv_shift_in),
        .cand_in_0(cand_in_0), .cand_in_1(cand_in_1), .cand_in_2(cand_in_2), .cand_in_3(cand_in_3),
        .lambda_int_in(lambda_int_in), .lambda_dec_in(lambda_dec_in),
        .eng_start(eng_start), .eng_ce(eng_ce), .eng_x(eng_x), .eng_y(eng_y),
        .eng_mv_shift(eng_mv_shift), .eng_cand_0(eng_cand_0), .eng_cand_1(eng_cand_1),
        .eng_cand_2(eng_cand_2), .eng_cand_3(eng_cand_3),
        .eng_lambda_int(eng_lambda_int), .eng_lambda_dec(eng_lambda_dec),
        .eng_cost(eng_cost), .eng_cost_vld(eng_cost_vld), .eng_bitcost(eng_bitcost),
        .busy(busy), .done(done), .best_x(best_x), .best_y(best_y),
        .best_cost(best_cost), .best_bitcost(best_bitcost), .err_orphan(err_orphan)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct { longint unsigned cost; longint unsigned bc; int due; } pend_t;
    typedef struct { int x; int y; longint unsigned cost; longint unsigned bc; } res_t;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_issue[$];
    res_t        exp_res[$];
    pend_t       pending[$];
    int eng_lat = 5, eng_mode = 0, eng_seed = 0, eng_cyc = 0, max_pend = 0;
    bit inject_req = 1'b0;
    longint unsigned last_cost = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint mvbits(input int v, input int c, input int sh);
        longint d;
        d = (longint'(v) <<< sh) - longint'(c);
        if (d < 0) d = -d;
        return 2 + d;
    endfunction

    // mode 0: bit-count style cost vs two candidate MVs; mode 1: small hash (many ties)
    task automatic model_cost(input int mode, input int x, input int y, input logic [63:0] cp,
                              input int sh, input longint unsigned lint, input longint unsigned ldec,
                              input int seed, output longint unsigned cost, output longint unsigned bc);
        longint b0, b1, b;
        int h;
        if (mode == 0) begin
            b0 = mvbits(x, int'($signed(cp[15:0])), sh) + mvbits(y, int'($signed(cp[31:16])), sh);
            b1 = mvbits(x, int'($signed(cp[47:32])), sh) + mvbits(y, int'($signed(cp[63:48])), sh);
            b  = (b0 < b1) ? b0 : b1;
            bc   = longint'(b) << 34;
            cost = ((longint'(b) * lint) << 34) + longint'(b) * ldec;
        end else begin
            h    = x * 7 + y * 13 + seed;
            h    = ((h % 5) + 5) % 5;
            cost = longint'(h);
            bc   = (longint'(x * 3 + y) & 64'hFFFF) + 100;
        end
    endtask

    // Reference: enumerate the window in raster order, keep the first strict minimum
    task automatic ref_search(input int cx, input int cy, input int r, input logic [63:0] cp,
                              input int sh, input longint unsigned lint, input longint unsigned ldec,
                              input int mode, input int seed);
        res_t e;
        longint unsigned c, b;
        e.x = 0; e.y = 0; e.cost = 64'hFFFF_FFFF_FFFF_FFFF; e.bc = 0;
        for (int y = cy - r; y <= cy + r; y++) begin
            for (int x = cx - r; x <= cx + r; x++) begin
                exp_issue.push_back({32'(x), 32'(y)});
                model_cost(mode, x, y, cp, sh, lint, ldec, seed, c, b);
                if (c < e.cost) begin
                    e.x = x; e.y = y; e.cost = c; e.bc = b;
                end
            end
        end
        exp_res.push_back(e);
        last_cost = e.cost;
    endtask

    // Engine model: returns results in order after eng_lat cycles
    initial begin
        pend_t p;
        longint unsigned c, b;
        forever begin
            @(negedge ap_clk);
            eng_cyc++;
            if (eng_start) begin
                model_cost(eng_mode, int'($signed(eng_x)), int'($signed(eng_y)),
                           {eng_cand_3, eng_cand_2, eng_cand_1, eng_cand_0}, int'(eng_mv_shift),
                           eng_lambda_int, eng_lambda_dec, eng_seed, c, b);
                p.cost = c; p.bc = b; p.due = eng_cyc + eng_lat;
                pending.push_back(p);
                if (pending.size() > max_pend) max_pend = pending.size();
            end
            if (inject_req) begin
                eng_cost_vld = 1'b1; eng_cost = '0; eng_bitcost = '0;
                inject_req = 1'b0;
            end else if (pending.size() > 0 && pending[0].due <= eng_cyc) begin
                p = pending.pop_front();
                eng_cost_vld = 1'b1; eng_cost = p.cost; eng_bitcost = p.bc;
            end else begin
                eng_cost_vld = 1'b0;
                eng_cost     = 64'($urandom_range(0, 3));
                eng_bitcost  = 64'($urandom);
            end
        end
    end

    // Monitor: issue order and final results against the scoreboard
    initial begin
        res_t e;
        forever begin
            @(negedge ap_clk);
            if (eng_start) begin
                chk("issue_ce", {63'd0, eng_ce}, 64'd1);
                if (exp_issue.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got (%0d,%0d) expected none",
                             $signed(eng_x), $signed(eng_y));
                end else begin
                    chk("issue_xy", {eng_x, eng_y}, exp_issue.pop_front());
                end
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    e = exp_res.pop_front();
                    chk("best_xy", {best_x, best_y}, {32'(e.x), 32'(e.y)});
                    chk("best_cost", best_cost, e.cost);
                    chk("best_bitcost", best_bitcost, e.bc);
                    chk("issues_left", 64'(exp_issue.size()), 64'd0);
                    chk("orphan_at_done", {63'd0, err_orphan}, 64'd0);
                end
            end
        end
    end

    task automatic run_search(input int cx, input int cy, input int r, input logic [63:0] cp,
                              input int sh, input longint unsigned lint, input longint unsigned ldec,
                              input int mode, input int lat, input int seed, input bit poke);
        int n, budget, i;
        eng_mode = mode; eng_lat = lat; eng_seed = seed; max_pend = 0;
        ref_search(cx, cy, r, cp, sh, lint, ldec, mode, seed);
        n = (2 * r + 1) * (2 * r + 1);
        budget = 3 * n + 60;
        @(negedge ap_clk);
        center_x = 32'(cx); center_y = 32'(cy); range = RANGE_W'(r); mv_shift_in = 32'(sh);
        {cand_in_3, cand_in_2, cand_in_1, cand_in_0} = cp;
        lambda_int_in = lint; lambda_dec_in = ldec;
        start = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        center_x = $urandom; center_y = $urandom; range = RANGE_W'($urandom);
        mv_shift_in = $urandom; {cand_in_1, cand_in_0} = $urandom; {cand_in_3, cand_in_2} = $urandom;
        lambda_int_in = {$urandom, $urandom}; lambda_dec_in = {$urandom, $urandom};
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("orphan_cleared", {63'd0, err_orphan}, 64'd0);
        if (poke) begin
            repeat (2) @(negedge ap_clk);
            start = 1'b1;
            @(negedge ap_clk);
            start = 1'b0;
        end
        i = 0;
        while (!done && i < budget) begin
            @(negedge ap_clk);
            i++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
            exp_issue.delete(); exp_res.delete();
        end else begin
            @(negedge ap_clk);
            chk("done_one_cycle", {63'd0, done}, 64'd0);
            chk("busy_after_done", {63'd0, busy}, 64'd0);
            chk("ce_after_done", {63'd0, eng_ce}, 64'd0);
        end
    endtask

    initial begin
        logic [63:0] cp;
        repeat (3) @(negedge ap_clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_start", {63'd0, eng_start}, 64'd0);
        chk("rst_ce", {63'd0, eng_ce}, 64'd0);
        chk("rst_best_xy", {best_x, best_y}, 64'd0);
        chk("rst_best_cost", best_cost, 64'd0);
        chk("rst_orphan", {63'd0, err_orphan}, 64'd0);
        ap_rst_n = 1'b1;

        // R=0 and R=1 around origin, candidates zero, lambda 1
        run_search(0, 0, 0, 64'd0, 0, 1, 0, 0, 5, 0, 1'b0);
        chk("r0_cost_literal", last_cost, 64'd68719476736);
        run_search(0, 0, 1, 64'd0, 0, 1, 0, 0, 5, 0, 1'b0);
        // Tie between (-1,-1) and (1,1): the earlier raster point must win
        run_search(0, 0, 1, {16'hFFFF, 16'hFFFF, 16'd1, 16'd1}, 0, 1, 0, 0, 5, 0, 1'b0);
        // Backpressure: engine latency longer than the tag FIFO
        run_search(17, -9, 2, 64'd0, 0, 1, 0, 1, 10, 3, 1'b0);
        chk("max_outstanding", 64'(max_pend), 64'(FIFO_DEPTH));

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 4; k++) cp[k*16 +: 16] = 16'(int'($urandom_range(0, 40)) - 20);
            run_search(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
                       int'($urandom_range(1, 4)), cp, int'($urandom_range(0, 2)),
                       64'($urandom_range(1, 3)), 64'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 1)), int'($urandom_range(1, 10)),
                       int'($urandom_range(0, 99)), t[0]);
        end

        // Orphan result in IDLE
        #2 inject_req = 1'b1;
        repeat (2) @(negedge ap_clk);
        chk("orphan_set", {63'd0, err_orphan}, 64'd1);
        chk("orphan_keeps_best", best_cost, last_cost);
        run_search(5, 5, 1, 64'd0, 1, 2, 7, 0, 4, 0, 1'b0);

        // Reset in the middle of ISSUE
        ref_search(-3, 4, 3, 64'd0, 0, 1, 0, 1, 1);
        eng_mode = 1; eng_seed = 1; eng_lat = 5;
        @(negedge ap_clk);
        center_x = -32'sd3; center_y = 32'd4; range = RANGE_W'(3); start = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        repeat (4) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_start", {63'd0, eng_start}, 64'd0);
        chk("midrst_ce", {63'd0, eng_ce}, 64'd0);
        chk("midrst_best_cost", best_cost, 64'd0);
        chk("midrst_eng_xy", {eng_x, eng_y}, 64'd0);
        exp_issue.delete(); exp_res.delete(); pending.delete();
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("midrst_no_done", {63'd0, busy}, 64'd0);
        run_search(-2, 2, 2, 64'd0, 0, 1, 0, 0, 6, 0, 1'b1);

        // Widest window the range port allows
        run_search(-100000, 50000, (1 << RANGE_W) - 1, 64'd0, 0, 1, 0, 1, 3, 11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
